red_pitaya_fads_sort_gate: RTL
==============================

// Module: red_pitaya_fads_sort_gate
// PURPOSE
//  Downstream of the FADS threshold detector: consumes its per-sample detect flag, measures each
//  droplet's above-threshold width, qualifies it against a width window and, after a programmable
//  flight delay, issues a fixed-length trigger pulse to the ASG/high-voltage sorting path.
//  Enforces a holdoff after each droplet so one droplet never produces two sort pulses.
// PARAMETERS
//  CW    16  width of all timing config/counters, in adc_clk_i cycles
//  NW    32  width of statistics counters
// PORTS
//  adc_clk_i        in   1   ADC clock; single clock domain
//  adc_rst_i        in   1   reset, asynchronous, active-high
//  det_i            in   1   detect flag from threshold stage (1 = sample above threshold)
//  cfg_en_i         in   1   1 = gate armed; 0 = finish current pulse, then stay IDLE
//  cfg_min_w_i      in   CW  minimum accepted droplet width (cycles, inclusive)
//  cfg_max_w_i      in   CW  maximum accepted droplet width (cycles, inclusive)
//  cfg_delay_i      in   CW  cycles from droplet falling edge to trigger assertion
//  cfg_pulse_i      in   CW  trigger pulse length (cycles); 0 treated as 1
//  cfg_holdoff_i    in   CW  dead time after pulse (or after reject) before re-arming
//  sort_trig_o      out  1   ASG sort trigger, registered
//  busy_o           out  1   1 whenever state != IDLE
//  last_width_o     out  CW  width of last completed droplet, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, all counters 0, sort_trig_o=0, busy_o=0, last_width_o=0. Reset is honoured
//    mid-pulse: sort_trig_o drops asynchronously.
//  - det_i registered once (det_q); rising edge = det_i & ~det_q, falling = ~det_i & det_q.
//  - States: IDLE, MEASURE, DELAY, FIRE, HOLDOFF.
//  - IDLE: on rising edge with cfg_en_i=1 -> MEASURE, width counter loaded with 1.
//  - MEASURE: width += 1 per cycle while det_q=1, saturating at 2^CW-1. On falling edge:
//    last_width_o <= width; if min<=width<=max -> DELAY (delay counter cleared), else -> HOLDOFF.
//    If min>max, every droplet rejects.
//  - DELAY: count to cfg_delay_i; cfg_delay_i=0 -> FIRE on next cycle. det_i edges ignored.
//  - FIRE: sort_trig_o=1 for exactly max(cfg_pulse_i,1) cycles; first asserted cycle is
//    cfg_delay_i+1 cycles after the falling-edge cycle of det_q. Then -> HOLDOFF.
//  - HOLDOFF: count cfg_holdoff_i cycles (0 -> IDLE next cycle); detections ignored, not queued.
//    A droplet still high when IDLE is re-entered is not counted (needs a fresh rising edge).
//  - cfg_en_i=0: IDLE ignores edges; MEASURE/DELAY abort -> HOLDOFF without pulse; FIRE completes.
//  - Config sampled live each cycle; software changes config only while busy_o=0.
//  - All outputs registered; no combinational path input->output.
// CONFIGURATION
//  FADS_SORT_STATS_EN defined: adds outputs droplet_cnt_o, sorted_cnt_o, reject_cnt_o (NW each),
//    plus input stats_clr_i (1 cycle, synchronous clear). droplet_cnt increments on every
//    MEASURE exit, sorted_cnt on every FIRE entry, reject_cnt on width-window reject; all wrap
//    at 2^NW; clear wins over simultaneous increment; reset clears all.
//  Not defined: those ports and counters do not exist; core behaviour identical.
// TESTING
//  1. min=5,max=20,delay=100,pulse=10,holdoff=50; det_i high 10 cycles -> sort_trig_o high
//     10 cycles starting 101 cycles after det_q falls; last_width_o=10.
//  2. Same cfg, det_i high 3 cycles then 25 cycles -> no pulse either time; last_width_o=3 then 25.
//  3. Second droplet arrives 20 cycles after first pulse ends (in holdoff) -> ignored; droplet
//     after holdoff -> sorted.
//  4. delay=0,pulse=0 -> 1-cycle pulse on cycle after falling edge; min=max=7, width 7 accepted.
//  5. Assert adc_rst_i mid-FIRE -> sort_trig_o=0 immediately, busy_o=0; cfg_en_i=0 during DELAY
//     -> no pulse, HOLDOFF then IDLE.
//  6. FADS_SORT_STATS_EN: 4 droplets (3 in window, 1 reject) -> counts 4/3/1; stats_clr_i -> 0.

Source files
------------

// File: rtl/red_pitaya_fads_sort_gate.sv
// FADS sort gate: measures droplet width from the detect flag, qualifies it and fires a delayed sort trigger.
// Optional statistics counters are built when FADS_SORT_STATS_EN is defined.
module red_pitaya_fads_sort_gate #(
  parameter int unsigned CW = 16,
  parameter int unsigned NW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          det_i,
  input  logic          cfg_en_i,
  input  logic [CW-1:0] cfg_min_w_i,
  input  logic [CW-1:0] cfg_max_w_i,
  input  logic [CW-1:0] cfg_delay_i,
  input  logic [CW-1:0] cfg_pulse_i,
  input  logic [CW-1:0] cfg_holdoff_i,
`ifdef FADS_SORT_STATS_EN
  input  logic          stats_clr_i,
  output logic [NW-1:0] droplet_cnt_o,
  output logic [NW-1:0] sorted_cnt_o,
  output logic [NW-1:0] reject_cnt_o,
`endif
  output logic          sort_trig_o,
  output logic          busy_o,
  output logic [CW-1:0] last_width_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEASURE,
    S_DELAY,
    S_FIRE,
    S_HOLDOFF
  } state_t;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] WSAT = '1;

  state_t        state_q, state_d;
  logic          det_q;
  logic          rise, fall;
  logic [CW-1:0] width_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] pulse_len;
  logic          in_win;
  logic          trig_d, busy_d;

  if (NW < 1) begin : g_nw_range
  end

  assign rise      = det_i & ~det_q;
  assign fall      = ~det_i & det_q;
  assign pulse_len = (cfg_pulse_i == '0) ? ONE : cfg_pulse_i;
  assign in_win    = (width_q >= cfg_min_w_i) && (width_q <= cfg_max_w_i);

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) det_q <= 1'b0;
    else           det_q <= det_i;
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (rise && cfg_en_i) state_d = S_MEASURE;
      S_MEASURE: begin
        if (!cfg_en_i)  state_d = S_HOLDOFF;
        else if (fall)  state_d = in_win ? S_DELAY : S_HOLDOFF;
      end
      S_DELAY: begin
        if (!cfg_en_i)                  state_d = S_HOLDOFF;
        else if (cnt_q >= cfg_delay_i)  state_d = S_FIRE;
      end
      S_FIRE:    if (cnt_q >= pulse_len)     state_d = S_HOLDOFF;
      S_HOLDOFF: if (cnt_q >= cfg_holdoff_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they align with the state register.
  always_comb begin
    trig_d = (state_d == S_FIRE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      sort_trig_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      sort_trig_o <= trig_d;
      busy_o      <= busy_d;
    end
  end

  // cnt_q is shared by DELAY/FIRE/HOLDOFF; FIRE starts at 1 because its entry cycle already drives the trigger.
  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      cnt_q        <= '0;
      width_q      <= '0;
      last_width_o <= '0;
    end else begin
      if (state_d != state_q)
        cnt_q <= (state_d == S_FIRE) ? ONE : '0;
      else if (state_q == S_DELAY || state_q == S_FIRE || state_q == S_HOLDOFF)
        cnt_q <= cnt_q + ONE;

      if (state_q == S_IDLE && state_d == S_MEASURE)
        width_q <= ONE;
      else if (state_q == S_MEASURE && state_d == S_MEASURE && det_q && width_q != WSAT)
        width_q <= width_q + ONE;

      if (state_q == S_MEASURE && cfg_en_i && fall)
        last_width_o <= width_q;
    end
  end

`ifdef FADS_SORT_STATS_EN
  logic measure_exit, fire_entry, win_reject;

  assign measure_exit = (state_q == S_MEASURE) && (state_d != S_MEASURE);
  assign fire_entry   = (state_d == S_FIRE) && (state_q != S_FIRE);
  assign win_reject   = (state_q == S_MEASURE) && cfg_en_i && fall && !in_win;

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      droplet_cnt_o <= '0;
      sorted_cnt_o  <= '0;
      reject_cnt_o  <= '0;
    end else if (stats_clr_i) begin
      droplet_cnt_o <= '0;
      sorted_cnt_o  <= '0;
      reject_cnt_o  <= '0;
    end else begin
      if (measure_exit) droplet_cnt_o <= droplet_cnt_o + NW'(1);
      if (fire_entry)   sorted_cnt_o  <= sorted_cnt_o + NW'(1);
      if (win_reject)   reject_cnt_o  <= reject_cnt_o + NW'(1);
    end
  end
`endif

endmodule
